// File: rtl/audio_mode_sequencer.sv
// Front-end controller for audio_preprocessor: feeds samples in, applies output gain,
// and sequences click-free filter-mode changes (fade out, switch, flush, fade in).
module audio_mode_sequencer #(
    parameter int PP_LAT        = 1,
    parameter int RAMP_STEP     = 16,
    parameter int FLUSH_SAMPLES = 8,
    parameter int DEFAULT_MODE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic [1:0]  mode_req,
    input  logic        mode_req_valid,
    output logic        mode_req_ready,
    output logic [1:0]  pp_filter_sel,
    output logic [15:0] pp_audio_in,
    input  logic [15:0] pp_audio_out,
    output logic        m_valid,
    output logic [15:0] m_data,
    output logic [1:0]  cur_mode,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN_S      = 2'd0,
        FADE_OUT_S = 2'd1,
        FLUSH_S    = 2'd2,
        FADE_IN_S  = 2'd3
    } state_t;

    localparam int FW = (FLUSH_SAMPLES < 2) ? 1 : $clog2(FLUSH_SAMPLES + 1);
    localparam logic [9:0]    STEP_C  = 10'(RAMP_STEP);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_SAMPLES);
    localparam logic [1:0]    DEF_C   = 2'(DEFAULT_MODE);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [8:0]        gain_r;
    logic [8:0]        gain_nxt_s;
    logic [1:0]        pending_r;
    logic [1:0]        pending_nxt_s;
    logic [1:0]        sel_r;
    logic [1:0]        sel_nxt_s;
    logic [FW-1:0]     flush_r;
    logic [FW-1:0]     flush_nxt_s;
    logic [PP_LAT-1:0] valid_pipe_r;
    logic [15:0]       pp_in_r;
    logic              m_valid_r;
    logic [15:0]       m_data_r;
    logic              sample_s;
    logic [9:0]        gain_ext_s;
    logic [9:0]        gain_sum_s;
    logic signed [25:0] prod_s;
    logic [15:0]       m_data_nxt_s;

    // One output sample per tap hit; all ramps advance on this, never on raw clocks.
    assign sample_s   = valid_pipe_r[PP_LAT-1];
    assign gain_ext_s = {1'b0, gain_r};
    assign gain_sum_s = gain_ext_s + STEP_C;
    assign prod_s     = $signed(pp_audio_out) * $signed(gain_ext_s);
    assign m_data_nxt_s = 16'(prod_s >>> 8);

    assign mode_req_ready = (state_r == RUN_S);
    assign busy           = (state_r != RUN_S);
    assign pp_filter_sel  = sel_r;
    assign cur_mode       = sel_r;
    assign pp_audio_in    = pp_in_r;
    assign m_valid        = m_valid_r;
    assign m_data         = m_data_r;

    // Next-state and gain/mode/flush-counter update logic.
    always_comb begin
        state_nxt_s   = state_r;
        gain_nxt_s    = gain_r;
        pending_nxt_s = pending_r;
        sel_nxt_s     = sel_r;
        flush_nxt_s   = flush_r;
        case (state_r)
            RUN_S: begin
                gain_nxt_s = 9'd256;
                if (mode_req_valid && (mode_req != sel_r)) begin
                    pending_nxt_s = mode_req;
                    state_nxt_s   = FADE_OUT_S;
                end else begin
                    state_nxt_s = RUN_S;
                end
            end
            FADE_OUT_S: begin
                if (sample_s) begin
                    if (gain_ext_s <= STEP_C) begin
                        // Filter is switched only once the output is fully silent.
                        gain_nxt_s  = 9'd0;
                        state_nxt_s = FLUSH_S;
                        sel_nxt_s   = pending_r;
                        flush_nxt_s = FLUSH_C;
                    end else begin
                        gain_nxt_s = 9'(gain_ext_s - STEP_C);
                    end
                end else begin
                    gain_nxt_s = gain_r;
                end
            end
            FLUSH_S: begin
                gain_nxt_s = 9'd0;
                if (sample_s) begin
                    if (flush_r <= FW'(1)) begin
                        flush_nxt_s = '0;
                        state_nxt_s = FADE_IN_S;
                    end else begin
                        flush_nxt_s = flush_r - FW'(1);
                    end
                end else begin
                    flush_nxt_s = flush_r;
                end
            end
            FADE_IN_S: begin
                if (sample_s) begin
                    if (gain_sum_s >= 10'd256) begin
                        gain_nxt_s  = 9'd256;
                        state_nxt_s = RUN_S;
                    end else begin
                        gain_nxt_s = 9'(gain_sum_s);
                    end
                end else begin
                    gain_nxt_s = gain_r;
                end
            end
            default: begin
                state_nxt_s = RUN_S;
                gain_nxt_s  = 9'd256;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= RUN_S;
            gain_r    <= 9'd256;
            pending_r <= 2'd0;
            sel_r     <= DEF_C;
            flush_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            gain_r    <= gain_nxt_s;
            pending_r <= pending_nxt_s;
            sel_r     <= sel_nxt_s;
            flush_r   <= flush_nxt_s;
        end
    end

    // Sample datapath: input register, latency-matching valid pipe, gained output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pp_in_r      <= 16'd0;
            valid_pipe_r <= '0;
            m_valid_r    <= 1'b0;
            m_data_r     <= 16'd0;
        end else begin
            if (s_valid) begin
                pp_in_r <= s_data;
            end else begin
                pp_in_r <= pp_in_r;
            end
            valid_pipe_r[0] <= s_valid;
            for (int i = 1; i < PP_LAT; i++) begin
                valid_pipe_r[i] <= valid_pipe_r[i-1];
            end
            m_valid_r <= sample_s;
            if (sample_s) begin
                m_data_r <= m_data_nxt_s;
            end else begin
                m_data_r <= m_data_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_mode_sequencer.sv
// Bench for audio_mode_sequencer: directed scenarios plus random traffic, checked against
// a model that precomputes each mode-change sequence as a queue of per-sample gains.
module tb_audio_mode_sequencer;

    localparam int STEP  = 16;
    localparam int FLUSH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic [1:0]  mode_req = 2'd0;
    logic        mode_req_valid = 1'b0;
    logic        mode_req_ready;
    logic [1:0]  pp_filter_sel;
    logic [15:0] pp_audio_in;
    logic [15:0] pp_audio_out;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  cur_mode;
    logic        busy;

    always #5 clk = ~clk;

    // Identity-delay preprocessor stub: output is valid for capture on the next edge.
    assign pp_audio_out = pp_audio_in;

    audio_mode_sequencer #(
        .PP_LAT(1), .RAMP_STEP(STEP), .FLUSH_SAMPLES(FLUSH), .DEFAULT_MODE(0)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
        .pp_filter_sel(pp_filter_sel), .pp_audio_in(pp_audio_in), .pp_audio_out(pp_audio_out),
        .m_valid(m_valid), .m_data(m_data), .cur_mode(cur_mode), .busy(busy)
    );

    typedef struct {
        int         gain;
        bit         sw;
        logic [1:0] mode;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] e_pp_in;
    logic [15:0] e_m_data;
    logic        e_m_valid;
    logic        e_pend;
    logic [1:0]  e_sel;
    logic        acc;

    function automatic void model_reset();
        q.delete();
        e_pp_in   = 16'd0;
        e_m_data  = 16'd0;
        e_m_valid = 1'b0;
        e_pend    = 1'b0;
        e_sel     = 2'd0;
    endfunction

    // Whole change sequence as the list of gains its output samples will see.
    function automatic void push_seq(input logic [1:0] m);
        ent_t e;
        for (int g = 256; g > 0; g -= STEP) begin
            e.gain = g; e.sw = (g - STEP <= 0); e.mode = m;
            q.push_back(e);
        end
        for (int k = 0; k < FLUSH; k++) begin
            e.gain = 0; e.sw = 1'b0; e.mode = m;
            q.push_back(e);
        end
        for (int g = 0; g < 256; g += STEP) begin
            e.gain = g; e.sw = 1'b0; e.mode = m;
            q.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_valid", 32'(m_valid), 32'(e_m_valid));
        chk("m_data", 32'(m_data), 32'(e_m_data));
        chk("pp_audio_in", 32'(pp_audio_in), 32'(e_pp_in));
        chk("pp_filter_sel", 32'(pp_filter_sel), 32'(e_sel));
        chk("cur_mode", 32'(cur_mode), 32'(e_sel));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("mode_req_ready", 32'(mode_req_ready), 32'(q.size() == 0));
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic step(input logic sv, input logic [15:0] sd, input logic rv,
                        input logic [1:0] rm, output logic accepted);
        int   g;
        ent_t e;
        s_valid = sv; s_data = sd; mode_req_valid = rv; mode_req = rm;
        accepted = rv && (q.size() == 0);
        if (e_pend) begin
            g = 256;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = e.gain;
                if (e.sw) e_sel = e.mode;
            end
            e_m_data = 16'((int'($signed(e_pp_in)) * g) >>> 8);
        end
        e_m_valid = e_pend;
        if (accepted && (rm != e_sel)) push_seq(rm);
        if (sv) e_pp_in = sd;
        e_pend = sv;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 2'd0, a);
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic a;
        logic held;
        model_reset();
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        idle(1);

        // Passthrough, including most negative sample
        step(1'b1, 16'd1000, 1'b0, 2'd0, a);
        step(1'b0, 16'd0, 1'b0, 2'd0, a);
        chk("pass_1000", 32'(m_data), 32'(16'd1000));
        step(1'b1, 16'h8000, 1'b0, 2'd0, a);
        step(1'b0, 16'd0, 1'b0, 2'd0, a);
        chk("pass_min", 32'(m_data), 32'(16'h8000));

        // Asynchronous reset mid-cycle clears outputs without an edge
        async_reset();
        idle(2);

        // Mode switch 0 -> 2 with constant input, one sample every 4 cycles
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 16'd16384, (k == 0), 2'd2, a);
            idle(3);
        end
        chk("mode_after_switch", 32'(cur_mode), 32'd2);

        // Same-mode request is a no-op
        step(1'b0, 16'd0, 1'b1, 2'd2, a);
        chk("same_mode_acc", 32'(a), 32'd1);
        idle(2);

        // Request held while busy is taken in the first RUN cycle
        held = 1'b0;
        step(1'b1, 16'd12000, 1'b1, 2'd0, a);
        for (int k = 0; k < 400; k++) begin
            if (!held) begin
                step((k % 3) == 0, 16'd12000, (k > 60), 2'd3, held);
            end else begin
                step((k % 3) == 0, 16'd12000, 1'b0, 2'd0, a);
            end
        end
        chk("held_req_taken", 32'(held), 32'd1);
        chk("mode_after_held", 32'(cur_mode), 32'd3);

        // Reset in the middle of a fade-out at gain 128
        step(1'b0, 16'd0, 1'b1, 2'd1, a);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'd1000, 1'b0, 2'd0, a);
            idle(1);
        end
        async_reset();
        step(1'b1, 16'd1000, 1'b0, 2'd0, a);
        step(1'b0, 16'd0, 1'b0, 2'd0, a);
        chk("post_reset_unscaled", 32'(m_data), 32'(16'd1000));
        chk("post_reset_mode", 32'(cur_mode), 32'd0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(2) == 0), 16'($urandom), ($urandom_range(15) == 0),
                 2'($urandom_range(3)), a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_mode_sequencer.md
# audio_mode_sequencer

Controller that sits in front of `audio_preprocessor` and owns its `filter_sel` input. It forwards a sample stream into the preprocessor, applies an output gain, and performs click-free filter-mode changes. A change is sequenced as: fade the output to silence, switch `filter_sel`, hold mute while the filter state settles, then fade back in. All ramps advance per output sample, not per clock.

## Interface
- `PP_LAT`, default 1: preprocessor latency in clocks, from a `pp_audio_in` change to a valid `pp_audio_out`.
- `RAMP_STEP`, default 16: gain change per output sample during a fade. Legal range 1..256.
- `FLUSH_SAMPLES`, default 8: number of muted output samples after the mode switch.
- `DEFAULT_MODE`, default 0: filter mode after reset.

Ports (name, direction, width, meaning):
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input sample strobe. No backpressure exists.
- `s_data`  in  16  signed input sample.
- `mode_req`  in  2  requested filter mode.
- `mode_req_valid`  in  1  mode request valid.
- `mode_req_ready`  out  1  request accepted on a cycle where valid and ready are both high.
- `pp_filter_sel`  out  2  drives the preprocessor `filter_sel`.
- `pp_audio_in`  out  16  drives the preprocessor `audio_in`. Registered.
- `pp_audio_out`  in  16  signed preprocessor output.
- `m_valid`  out  1  output sample strobe, one cycle wide.
- `m_data`  out  16  signed gained output sample.
- `cur_mode`  out  2  equal to `pp_filter_sel`.
- `busy`  out  1  high whenever the state is not RUN.

## Operation
- Reset values (when `rst` = 0):
  - `pp_filter_sel` and `cur_mode` = `DEFAULT_MODE`.
  - `pp_audio_in` = 0, `m_valid` = 0, `m_data` = 0.
  - gain = 256, state = RUN.
  - valid pipeline cleared, pending mode cleared.
  - `busy` = 0, `mode_req_ready` = 1.
- Datapath:
  - On `s_valid`, `s_data` is registered into `pp_audio_in`.
  - A `PP_LAT`-deep valid shift register marks when `pp_audio_out` is valid.
  - When that tap fires, `m_data` is registered and `m_valid` pulses.
  - `m_data` = (`pp_audio_out` × gain) >>> 8. This is a 16×9 signed product with an arithmetic shift (floor); no saturation is needed because gain ≤ 256.
- Gain is a 9-bit register in 0..256. Each output sample uses the current gain; the gain update for the FSM takes effect after that sample.
- `mode_req_ready` = (state == RUN). The signal is combinational from the state.
- FSM:
  - **RUN**: gain = 256.
    - Accepted request with `mode_req` == `cur_mode`: no-op, stay in RUN.
    - Accepted request with a different mode: latch the pending mode, go to FADE_OUT.
  - **FADE_OUT**: on each output sample, gain = max(gain − `RAMP_STEP`, 0). When the updated gain is 0, go to FLUSH. On that same edge, load `pp_filter_sel` with the pending mode and load the flush counter with `FLUSH_SAMPLES`.
  - **FLUSH**: gain = 0. The counter decrements on each output sample. At 0, go to FADE_IN.
  - **FADE_IN**: on each output sample, gain = min(gain + `RAMP_STEP`, 256). When the updated gain is 256, go to RUN.
- Boundary rules:
  - With no samples flowing, the FSM holds its state indefinitely. Fades are strictly sample-driven.
  - Input samples keep flowing through the preprocessor during every state.
  - A request presented while busy is not accepted. The requester must hold it; it is accepted in the first RUN cycle.
  - A request accepted in the same cycle as an output sample: that sample still uses gain 256.
  - `rst` asserted mid-sequence aborts immediately to the reset values, including `DEFAULT_MODE`. The pending mode is discarded.

## Timing
- Sample latency: `s_valid` high in cycle t → `pp_audio_in` updated at the end of t → `m_valid` high in cycle t+`PP_LAT`+1 (t+2 with the default).
- Mode request acceptance: single cycle. `busy` rises in the cycle after acceptance.
- `pp_filter_sel` changes exactly once per sequence, on the FADE_OUT→FLUSH edge, and never while gain ≠ 0.
- Sequence length with defaults: 16 fade-out samples + 8 flush samples + 16 fade-in samples. The return to RUN happens on the edge after the 40th output sample following acceptance.
- `m_valid` never pulses on two consecutive cycles unless `s_valid` did.

## Test plan
- **Reset values**: hold `rst` = 0 for 3 cycles → `pp_filter_sel` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0, `mode_req_ready` = 1. Then assert `rst` = 0 asynchronously mid-cycle → outputs clear without waiting for a clock edge.
- **Passthrough**: use an identity-delay stub as the preprocessor. `s_valid` with `s_data` = 1000 in cycle t → `m_valid` pulses in t+2 with `m_data` = 1000. `s_data` = −32768 → `m_data` = −32768.
- **Mode switch 0→2**: constant input 16384, one sample every 4 cycles, `mode_req` = 2. Required outputs: 16384, 15360, …, 1024 (16 samples), then eight 0s, then 0, 1024, …, 15360, then 16384 steady. `pp_filter_sel` becomes 2 right after the 1024 fade-out sample. `busy` falls after the 15360 fade-in sample.
- **Same-mode request**: request mode 0 while in mode 0 → accepted in 1 cycle, `busy` stays 0, outputs unchanged.
- **Request while busy**: request mode 3 during FLUSH → `mode_req_ready` = 0 throughout. The held request is accepted in the first RUN cycle, and a second full sequence follows.
- **Reset mid-fade**: assert `rst` during FADE_OUT with gain = 128 → state = RUN, gain = 256, `pp_filter_sel` = `DEFAULT_MODE`. The next sample (1000) passes through unscaled as 1000.
